ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 RegWriteD, ResultSrcD, MemWriteD, ALUSrcD, BranchD, JumpD  input  1 each  decoded controls from the control unit, ID stage.
REQ-004 ALUControlD  input  3  ALU operation, ID stage.
REQ-005 RdD, Rs1D, Rs2D  input  5 each  destination and source register indices, ID stage.
REQ-006 ZeroE  input  1  ALU zero flag, EX stage.
REQ-007 RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, BranchE, JumpE, ALUControlE[2:0], RdE[4:0]  output  EX-stage controls.
REQ-008 RegWriteM, ResultSrcM, MemWriteM, RdM[4:0]  output  MEM-stage controls.
REQ-009 RegWriteW, ResultSrcW, RdW[4:0]  output  WB-stage controls.
REQ-010 PCSrcE  output  1  redirect PC to branch or jump target.
REQ-011 StallF, StallD, FlushD  output  1 each  hazard controls to the IF/ID logic.

Function
REQ-012 The E register SHALL capture all D controls and RdD on every edge unless bubbleE is 1.
REQ-013 bubbleE = PCSrcE | loadUse; a bubble SHALL load all E controls, ALUControlE and RdE as 0.
REQ-014 The M register SHALL capture E values and the W register SHALL capture M values on every edge, with no stall or flush.
REQ-015 Latency SHALL be 1 cycle from D to E, 2 cycles to M and 3 cycles to W.
REQ-016 RegWrite SHALL be forced to 0 at E capture when RdD = 0.
REQ-017 PCSrcE = JumpE | (BranchE & ZeroE), combinational from registered E state.
REQ-018 loadUse = ResultSrcE & RegWriteE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D), combinational.
REQ-019 StallF = StallD = loadUse & ~PCSrcE.
REQ-020 FlushD = PCSrcE.
REQ-021 Simultaneous loadUse and PCSrcE: flush SHALL win, with stalls 0, FlushD 1 and an E bubble.
REQ-022 A D-stage instruction held by a stall SHALL enter E on the first cycle loadUse is 0.
REQ-023 Undecoded instructions (ALUControlD = 111, all enables 0) SHALL pass through as harmless no-ops.

Reset
REQ-024 Reset SHALL clear every E, M and W register, including ALUControlE, to 0.
REQ-025 Reset SHALL override bubble and capture on the same edge.
REQ-026 A reset mid-operation SHALL leave no in-flight write or store, so RegWriteM/W and MemWriteM are 0 from the next edge.
REQ-027 After reset, PCSrcE, StallF, StallD and FlushD SHALL be 0 until a non-zero D input arrives.

Configuration
REQ-028 With macro CTRL_PIPE_PERF_EN defined, the block SHALL add output bubble_count[31:0], which increments on each edge where bubbleE is 1, wraps at 2^32 and is cleared by reset.
REQ-029 Without CTRL_PIPE_PERF_EN, bubble_count SHALL be absent, with no counter logic and unchanged behaviour.

Structure
REQ-030 Shared package ctrl_pkg SHALL hold the ALUControl encodings (ADD 000, SUB 001, AND 010, OR 011, SLT 101, INV 111) and the opcode constants.
REQ-031 The package SHALL also hold the E/M/W control-bundle widths.
REQ-032 Load-use and redirect logic SHALL live in sub-module hazard_detect, which is purely combinational.
REQ-033 All pipeline registers SHALL reside in ctrl_pipe.

Verification
REQ-034 add x5 (RegWriteD 1, RdD 5) held one cycle -> RegWriteE/M/W = 1 with Rd 5 at cycles 1/2/3.
REQ-035 lw x6 followed by add rs1 = x6 -> StallF = StallD = 1 for exactly 1 cycle, then E bubble, then add enters E.
REQ-036 beq with ZeroE 1 -> PCSrcE 1 and FlushD 1 for one cycle; the next E is all-zero; ZeroE 0 gives no flush.
REQ-037 lw in E matching Rs1D while jal is in E (PCSrcE 1) -> StallF 0, FlushD 1, E bubble.
REQ-038 Reset asserted with sw in M -> MemWriteM 0 after the edge; all outputs 0.
REQ-039 Write to x0 (RdD 0, RegWriteD 1) -> RegWriteE 0; with CTRL_PIPE_PERF_EN, 3 bubbles -> bubble_count 3.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control encodings and pipeline bundle types for ctrl_pipe.
package ctrl_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_INV = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int E_CTRL_W = 14;
    localparam int M_CTRL_W = 8;
    localparam int W_CTRL_W = 7;

    typedef struct packed {
        logic       reg_write;
        logic       result_src;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] alu_control;
        logic [4:0] rd;
    } e_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       result_src;
        logic       mem_write;
        logic [4:0] rd;
    } m_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       result_src;
        logic [4:0] rd;
    } w_ctrl_t;

    function automatic m_ctrl_t to_m(input e_ctrl_t e);
        m_ctrl_t m;
        m.reg_write  = e.reg_write;
        m.result_src = e.result_src;
        m.mem_write  = e.mem_write;
        m.rd         = e.rd;
        return m;
    endfunction

    function automatic w_ctrl_t to_w(input m_ctrl_t m);
        w_ctrl_t w;
        w.reg_write  = m.reg_write;
        w.result_src = m.result_src;
        w.rd         = m.rd;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_detect.sv
// Combinational load-use and redirect detection for ctrl_pipe.
module hazard_detect
    import ctrl_pkg::*;
(
    input  logic       reg_write_e,
    input  logic       result_src_e,
    input  logic       branch_e,
    input  logic       jump_e,
    input  logic       zero_e,
    input  logic [4:0] rd_e,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    output logic       pc_src_e,
    output logic       bubble_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d
);

    logic load_use;

    always_comb begin
        pc_src_e = jump_e | (branch_e & zero_e);
        load_use = result_src_e & reg_write_e & (rd_e != 5'd0)
                 & ((rd_e == rs1_d) | (rd_e == rs2_d));
        // A redirect kills the stalled instruction, so flush wins.
        stall_f  = load_use & ~pc_src_e;
        stall_d  = load_use & ~pc_src_e;
        flush_d  = pc_src_e;
        bubble_e = pc_src_e | load_use;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// E/M/W control pipeline registers; CTRL_PIPE_PERF_EN adds bubble_count.
module ctrl_pipe
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
`ifdef CTRL_PIPE_PERF_EN
    output logic [31:0] bubble_count,
`endif
    input  logic        RegWriteD,
    input  logic        ResultSrcD,
    input  logic        MemWriteD,
    input  logic        ALUSrcD,
    input  logic        BranchD,
    input  logic        JumpD,
    input  logic [2:0]  ALUControlD,
    input  logic [4:0]  RdD,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic        ZeroE,
    output logic        RegWriteE,
    output logic        ResultSrcE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic        BranchE,
    output logic        JumpE,
    output logic [2:0]  ALUControlE,
    output logic [4:0]  RdE,
    output logic        RegWriteM,
    output logic        ResultSrcM,
    output logic        MemWriteM,
    output logic [4:0]  RdM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RdW,
    output logic        PCSrcE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD
);

    e_ctrl_t e_d, e_q;
    m_ctrl_t m_d, m_q;
    w_ctrl_t w_d, w_q;
    logic    bubble_e;

    hazard_detect u_hazard (
        .reg_write_e  (e_q.reg_write),
        .result_src_e (e_q.result_src),
        .branch_e     (e_q.branch),
        .jump_e       (e_q.jump),
        .zero_e       (ZeroE),
        .rd_e         (e_q.rd),
        .rs1_d        (Rs1D),
        .rs2_d        (Rs2D),
        .pc_src_e     (PCSrcE),
        .bubble_e     (bubble_e),
        .stall_f      (StallF),
        .stall_d      (StallD),
        .flush_d      (FlushD)
    );

    always_comb begin
        e_d = '0;
        if (!bubble_e) begin
            // Writes to x0 are dropped here so later stages never see them.
            e_d.reg_write   = RegWriteD & (RdD != 5'd0);
            e_d.result_src  = ResultSrcD;
            e_d.mem_write   = MemWriteD;
            e_d.alu_src     = ALUSrcD;
            e_d.branch      = BranchD;
            e_d.jump        = JumpD;
            e_d.alu_control = ALUControlD;
            e_d.rd          = RdD;
        end
        m_d = to_m(e_q);
        w_d = to_w(m_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] bubble_count_d, bubble_count_q;

    always_comb begin
        bubble_count_d = bubble_count_q + {31'd0, bubble_e};
    end

    always_ff @(posedge clk) begin
        if (reset) bubble_count_q <= '0;
        else       bubble_count_q <= bubble_count_d;
    end

    assign bubble_count = bubble_count_q;
`endif

    assign RegWriteE   = e_q.reg_write;
    assign ResultSrcE  = e_q.result_src;
    assign MemWriteE   = e_q.mem_write;
    assign ALUSrcE     = e_q.alu_src;
    assign BranchE     = e_q.branch;
    assign JumpE       = e_q.jump;
    assign ALUControlE = e_q.alu_control;
    assign RdE         = e_q.rd;
    assign RegWriteM   = m_q.reg_write;
    assign ResultSrcM  = m_q.result_src;
    assign MemWriteM   = m_q.mem_write;
    assign RdM         = m_q.rd;
    assign RegWriteW   = w_q.reg_write;
    assign ResultSrcW  = w_q.result_src;
    assign RdW         = w_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed D vectors, monitor checks E/M/W and hazards.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic RegWriteD, ResultSrcD, MemWriteD, ALUSrcD, BranchD, JumpD;
    logic [2:0] ALUControlD;
    logic [4:0] RdD, Rs1D, Rs2D;
    logic ZeroE;
    logic RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [2:0] ALUControlE;
    logic [4:0] RdE;
    logic RegWriteM, ResultSrcM, MemWriteM;
    logic [4:0] RdM;
    logic RegWriteW, ResultSrcW;
    logic [4:0] RdW;
    logic PCSrcE, StallF, StallD, FlushD;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] bubble_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk(clk), .reset(reset),
`ifdef CTRL_PIPE_PERF_EN
        .bubble_count(bubble_count),
`endif
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
        .BranchD(BranchD), .JumpD(JumpD),
        .ALUControlD(ALUControlD), .RdD(RdD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .ZeroE(ZeroE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE),
        .ALUControlE(ALUControlE), .RdE(RdE),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .RdM(RdM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .PCSrcE(PCSrcE), .StallF(StallF),
        .StallD(StallD), .FlushD(FlushD)
    );

    typedef struct packed {
        logic       rst;
        e_ctrl_t    en;
        logic [3:0] haz;
    } item_t;

    item_t q[$];

    localparam logic [3:0] H_NONE  = 4'b0000;
    localparam logic [3:0] H_STALL = 4'b0110;
    localparam logic [3:0] H_FLUSH = 4'b1001;

    function automatic e_ctrl_t mk(input logic rw, rs, mw, as, br, jp,
                                   input logic [2:0] alu,
                                   input logic [4:0] rd);
        e_ctrl_t e;
        e = '{rw, rs, mw, as, br, jp, alu, rd};
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected E state during a cycle is the previous vector's E result.
    e_ctrl_t e1 = '0, e2 = '0, e3 = '0;
    int cyc = 0;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            item_t it;
            e_ctrl_t e_act;
            m_ctrl_t m_act;
            w_ctrl_t w_act;
            it = q.pop_front();
            cyc++;
            e_act = '{RegWriteE, ResultSrcE, MemWriteE, ALUSrcE,
                      BranchE, JumpE, ALUControlE, RdE};
            m_act = '{RegWriteM, ResultSrcM, MemWriteM, RdM};
            w_act = '{RegWriteW, ResultSrcW, RdW};
            check($sformatf("E_c%0d", cyc), 32'(e_act), 32'(e1));
            check($sformatf("M_c%0d", cyc), 32'(m_act), 32'(to_m(e2)));
            check($sformatf("W_c%0d", cyc), 32'(w_act),
                  32'(to_w(to_m(e3))));
            check($sformatf("HAZ_c%0d", cyc),
                  32'({PCSrcE, StallF, StallD, FlushD}), 32'(it.haz));
            if (it.rst) begin
                e1 = '0; e2 = '0; e3 = '0;
            end else begin
                e3 = e2; e2 = e1; e1 = it.en;
            end
        end
    end

    task automatic v(input logic rst, input e_ctrl_t d,
                     input logic [4:0] rs1, rs2, input logic zero,
                     input e_ctrl_t en, input logic [3:0] haz);
        item_t it;
        @(posedge clk);
        #1;
        reset = rst;
        {RegWriteD, ResultSrcD, MemWriteD, ALUSrcD,
         BranchD, JumpD, ALUControlD, RdD} = d;
        Rs1D = rs1;
        Rs2D = rs2;
        ZeroE = zero;
        it.rst = rst;
        it.en = en;
        it.haz = haz;
        q.push_back(it);
    endtask

    e_ctrl_t NOP, ADD5, LW6, ADD7, BEQ, ADD8, LJ6, X0, X0E;
    e_ctrl_t INV9, ADD10, SW;

    initial begin
        NOP   = '0;
        ADD5  = mk(1, 0, 0, 0, 0, 0, ALU_ADD, 5);
        LW6   = mk(1, 1, 0, 1, 0, 0, ALU_ADD, 6);
        ADD7  = mk(1, 0, 0, 0, 0, 0, ALU_ADD, 7);
        BEQ   = mk(0, 0, 0, 0, 1, 0, ALU_SUB, 0);
        ADD8  = mk(1, 0, 0, 0, 0, 0, ALU_ADD, 8);
        LJ6   = mk(1, 1, 0, 0, 0, 1, ALU_ADD, 6);
        X0    = mk(1, 0, 0, 0, 0, 0, ALU_OR, 0);
        X0E   = mk(0, 0, 0, 0, 0, 0, ALU_OR, 0);
        INV9  = mk(0, 0, 0, 0, 0, 0, ALU_INV, 9);
        ADD10 = mk(1, 0, 0, 0, 0, 0, ALU_ADD, 10);
        SW    = mk(0, 0, 1, 1, 0, 0, ALU_ADD, 0);

        reset = 1'b1;
        {RegWriteD, ResultSrcD, MemWriteD, ALUSrcD, BranchD, JumpD} = '0;
        ALUControlD = '0; RdD = '0; Rs1D = '0; Rs2D = '0; ZeroE = 1'b0;
        repeat (2) @(posedge clk);

        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
        v(0, ADD5,  1, 2, 0, ADD5,  H_NONE);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
        v(0, LW6,   2, 0, 0, LW6,   H_NONE);
        v(0, ADD7,  6, 3, 0, NOP,   H_STALL);
        v(0, ADD7,  6, 3, 0, ADD7,  H_NONE);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
        v(0, BEQ,   1, 2, 0, BEQ,   H_NONE);
        v(0, ADD8,  0, 0, 1, NOP,   H_FLUSH);
        v(0, NOP,   0, 0, 1, NOP,   H_NONE);
        v(0, BEQ,   1, 2, 0, BEQ,   H_NONE);
        v(0, ADD8,  0, 0, 0, ADD8,  H_NONE);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
        v(0, LJ6,   0, 0, 0, LJ6,   H_NONE);
        v(0, ADD7,  6, 0, 0, NOP,   H_FLUSH);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
        v(0, X0,    0, 0, 0, X0E,   H_NONE);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
        v(0, INV9,  9, 0, 0, INV9,  H_NONE);
        v(0, ADD10, 9, 0, 0, ADD10, H_NONE);
        v(0, SW,    2, 3, 0, SW,    H_NONE);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
`ifdef CTRL_PIPE_PERF_EN
        check("bubble_count", bubble_count, 32'd3);
`endif
        v(1, ADD5,  0, 0, 0, NOP,   H_NONE);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
        v(0, NOP,   0, 0, 0, NOP,   H_NONE);
`ifdef CTRL_PIPE_PERF_EN
        check("bubble_count_rst", bubble_count, 32'd0);
`endif

        repeat (3) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
